// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS pipeline: load-use stalls,
// branch flushes, and a data-memory wait FSM with timeout detection.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             ifid_uses_rt_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             idex_memread_i,
  input  logic             exmem_memaccess_i,
  input  logic             dmem_ready_i,
  input  logic             branch_taken_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             idex_bubble_o,
  output logic             ifid_flush_o,
  output logic             pipe_freeze_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       memwait;
  logic       loaduse;

  // $0 is hardwired to zero, so a load targeting it can never create a hazard.
  assign loaduse = idex_memread_i && (idex_rt_i != 5'd0) &&
                   ((idex_rt_i == ifid_rs_i) ||
                    (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    memwait      = 1'b0;
    case (state)
      RUN: begin
        memwait = exmem_memaccess_i && !dmem_ready_i;
        if (memwait) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end
      end
      MEM_WAIT: begin
        memwait = !dmem_ready_i;
        if (dmem_ready_i) begin
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
        end else if (wait_cnt == TIMEOUT) begin
          state_nxt = ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  // Priority: reset > ERR > memwait > loaduse > branch. Release from MEM_WAIT
  // is zero-cycle because memwait drops in the same cycle ready arrives.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    idex_bubble_o = 1'b0;
    ifid_flush_o  = 1'b0;
    pipe_freeze_o = 1'b0;
    err_o         = 1'b0;
    if (!rst_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (state == ERR) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      pipe_freeze_o = 1'b1;
      err_o         = 1'b1;
    end else if (memwait) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      pipe_freeze_o = 1'b1;
    end else if (loaduse) begin
      // A same-cycle taken branch is dropped; it re-resolves after the stall.
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      stall_cnt_o <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (!pc_write_o && (state != ERR) && (stall_cnt_o != {CNT_W{1'b1}}))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected outputs are queued with each
// stimulus vector and compared half a cycle later, before the next rising edge.
module tb_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  ifid_rs_i, ifid_rt_i, idex_rt_i;
  logic        ifid_uses_rt_i, idex_memread_i, exmem_memaccess_i;
  logic        dmem_ready_i, branch_taken_i;
  logic        pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o;
  logic        pipe_freeze_o, err_o;
  logic [15:0] stall_cnt_o;

  logic        pc_write_2, ifid_write_2, idex_bubble_2, ifid_flush_2;
  logic        pipe_freeze_2, err_2;
  logic [1:0]  stall_cnt_2;

  typedef struct {
    logic        pc;
    logic        ifid;
    logic        bub;
    logic        fl;
    logic        fz;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i), .ifid_uses_rt_i(ifid_uses_rt_i),
    .idex_rt_i(idex_rt_i), .idex_memread_i(idex_memread_i),
    .exmem_memaccess_i(exmem_memaccess_i), .dmem_ready_i(dmem_ready_i),
    .branch_taken_i(branch_taken_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
    .idex_bubble_o(idex_bubble_o), .ifid_flush_o(ifid_flush_o),
    .pipe_freeze_o(pipe_freeze_o), .err_o(err_o), .stall_cnt_o(stall_cnt_o)
  );

  // Narrow counter copy fed the same stimulus, used to observe saturation.
  hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(2)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i), .ifid_uses_rt_i(ifid_uses_rt_i),
    .idex_rt_i(idex_rt_i), .idex_memread_i(idex_memread_i),
    .exmem_memaccess_i(exmem_memaccess_i), .dmem_ready_i(dmem_ready_i),
    .branch_taken_i(branch_taken_i),
    .pc_write_o(pc_write_2), .ifid_write_o(ifid_write_2),
    .idex_bubble_o(idex_bubble_2), .ifid_flush_o(ifid_flush_2),
    .pipe_freeze_o(pipe_freeze_2), .err_o(err_2), .stall_cnt_o(stall_cnt_2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic drive(input logic rst, input logic memread, input logic [4:0] irt,
                       input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic access, input logic ready, input logic branch);
    rst_i             = rst;
    idex_memread_i    = memread;
    idex_rt_i         = irt;
    ifid_rs_i         = rs;
    ifid_rt_i         = rt;
    ifid_uses_rt_i    = uses;
    exmem_memaccess_i = access;
    dmem_ready_i      = ready;
    branch_taken_i    = branch;
  endtask

  task automatic compare(input string tag);
    exp_t        e;
    logic [15:0] sat;
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
      return;
    end
    e   = exp_q.pop_front();
    sat = (e.cnt > 16'd3) ? 16'd3 : e.cnt;
    check({tag, ".pc_write"},  32'(pc_write_o),    32'(e.pc));
    check({tag, ".ifid_write"},32'(ifid_write_o),  32'(e.ifid));
    check({tag, ".bubble"},    32'(idex_bubble_o), 32'(e.bub));
    check({tag, ".flush"},     32'(ifid_flush_o),  32'(e.fl));
    check({tag, ".freeze"},    32'(pipe_freeze_o), 32'(e.fz));
    check({tag, ".err"},       32'(err_o),         32'(e.err));
    check({tag, ".stall_cnt"}, 32'(stall_cnt_o),   32'(e.cnt));
    check({tag, ".sat_cnt"},   32'(stall_cnt_2),   32'(sat));
  endtask

  // Drive one vector after the falling edge, queue its expectation, and
  // compare mid-phase so the Mealy outputs have settled before the rising edge.
  task automatic step(input string tag,
                      input logic rst, input logic memread, input logic [4:0] irt,
                      input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                      input logic access, input logic ready, input logic branch,
                      input logic pc, input logic ifid, input logic bub, input logic fl,
                      input logic fz, input logic err, input logic [15:0] cnt);
    exp_t e;
    @(negedge clk_i);
    drive(rst, memread, irt, rs, rt, uses, access, ready, branch);
    e.pc = pc; e.ifid = ifid; e.bub = bub; e.fl = fl;
    e.fz = fz; e.err = err; e.cnt = cnt;
    exp_q.push_back(e);
    #2;
    compare(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    //    tag          rst mr irt rs rt us ac rd br   pc if bu fl fz er cnt
    step("reset0",     0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 0, 0, 0);
    step("reset1",     0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 0, 0, 0);
    step("idle",       1, 0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0, 0, 0);
    step("loaduse",    1, 1, 5, 5, 0, 0, 0, 1, 0,   0, 0, 1, 0, 0, 0, 0);
    step("after_lu",   1, 0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0, 0, 1);
    step("reg_zero",   1, 1, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0, 0, 1);
    step("rt_unused",  1, 1, 7, 3, 7, 0, 0, 1, 0,   1, 1, 0, 0, 0, 0, 1);
    step("rt_used",    1, 1, 7, 3, 7, 1, 0, 1, 0,   0, 0, 1, 0, 0, 0, 1);
    step("lu_branch",  1, 1, 5, 5, 0, 0, 0, 1, 1,   0, 0, 1, 0, 0, 0, 2);
    step("branch",     1, 0, 0, 0, 0, 0, 0, 1, 1,   1, 1, 0, 1, 0, 0, 3);
    step("mw_start",   1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 3);
    step("mw_1",       1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 4);
    step("mw_2",       1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 5);
    step("mw_ready",   1, 0, 0, 0, 0, 0, 1, 1, 0,   1, 1, 0, 0, 0, 0, 6);
    step("lu_frozen",  1, 1, 5, 5, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 6);
    step("lu_release", 1, 1, 5, 5, 0, 0, 1, 1, 0,   0, 0, 1, 0, 0, 0, 7);
    step("idle2",      1, 0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0, 0, 8);
    step("to_start",   1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 8);
    step("to_w1",      1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 9);
    step("to_w2",      1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 10);
    step("to_w3",      1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 11);
    step("to_w4",      1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 12);
    step("err",        1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 1, 13);
    step("err_ready",  1, 1, 5, 5, 0, 0, 1, 1, 1,   0, 0, 0, 0, 1, 1, 13);
    step("err_idle",   1, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 1, 13);
    step("rst_in_err", 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 0, 0, 0);
    step("post_err",   1, 0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0, 0, 0);
    step("mw2_start",  1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 0);
    step("mw2_w1",     1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 1);
    step("rst_in_mw",  0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 0, 0, 0);
    step("rst_hold",   0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 0, 0, 0);
    step("post_rst",   1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0);
    step("post_idle",  1, 0, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0, 0, 0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS core. It complements the forwarding unit: it handles the hazards forwarding cannot resolve.
- Detects load-use hazards between the ID/EX and IF/ID stages, and flushes IF/ID on a taken branch resolved in ID.
- Runs a data-memory wait FSM that freezes the whole pipeline until the data memory signals ready, with timeout error detection.
- Sits in the top-level CPU beside the forwarding unit and drives the PC, IF/ID, ID/EX and back-end pipeline register enables.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before entering ERR (range 1..255)
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-low
ifid_rs_i  input  5  rs field of instruction in IF/ID
ifid_rt_i  input  5  rt field of instruction in IF/ID
ifid_uses_rt_i  input  1  IF/ID instruction reads rt as a source
idex_rt_i  input  5  destination rt of instruction in ID/EX
idex_memread_i  input  1  ID/EX instruction is a load
exmem_memaccess_i  input  1  EX/MEM instruction is a load or store
dmem_ready_i  input  1  data memory access completes this cycle
branch_taken_i  input  1  branch resolved taken in ID
pc_write_o  output  1  PC register write enable
ifid_write_o  output  1  IF/ID register write enable
idex_bubble_o  output  1  load zero control signals into ID/EX (bubble)
ifid_flush_o  output  1  clear IF/ID to NOP
pipe_freeze_o  output  1  hold ID/EX, EX/MEM, MEM/WB and PC
err_o  output  1  memory timeout error, sticky
stall_cnt_o  output  CNT_W  saturating count of cycles with pc_write_o=0

Behaviour:
- Reset (rst_i=0, async): state=RUN, wait counter=0, stall_cnt_o=0, err_o=0. While reset is held: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0, pipe_freeze_o=0.
- FSM states: RUN, MEM_WAIT, ERR. Outputs are combinational (Mealy) from state and inputs; state and counters are registered.
- memwait = exmem_memaccess_i & ~dmem_ready_i in RUN; memwait = ~dmem_ready_i in MEM_WAIT.
- loaduse = idex_memread_i & (idex_rt_i!=0) & ((idex_rt_i==ifid_rs_i) | (ifid_uses_rt_i & idex_rt_i==ifid_rt_i)).
- RUN transitions:
  - memwait=1 -> MEM_WAIT next cycle; wait counter loads 1.
  - Otherwise stay in RUN.
- MEM_WAIT transitions:
  - dmem_ready_i=1 -> RUN next cycle; wait counter clears.
  - Else if wait counter==MEM_TIMEOUT -> ERR.
  - Else wait counter increments.
- ERR: absorbing until reset. err_o=1 and pipe_freeze_o=1; all enables held low.
- Output priority, highest first: reset > ERR > memwait > loaduse > branch.
  - memwait: pipe_freeze_o=1, pc_write_o=0, ifid_write_o=0, idex_bubble_o=0, ifid_flush_o=0.
  - loaduse (no memwait): pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0. A branch_taken_i in the same cycle is ignored; the branch re-resolves after the stall.
  - branch only: ifid_flush_o=1; pc_write_o=1, ifid_write_o=1 (the flush overrides the write).
  - Default: pc_write_o=1, ifid_write_o=1, all other outputs 0.
- Release latency: in the cycle where dmem_ready_i=1 in MEM_WAIT, pipe_freeze_o=0 in that same cycle (zero-cycle release).
- Load-use stall length: exactly one cycle. The next cycle the load has moved to EX/MEM, so idex_memread_i=0 unless a new load is present.
- Register $0 never causes a stall (idex_rt_i==0 excluded).
- Load-use under freeze: if loaduse and memwait coincide, only the freeze applies. Load-use re-evaluates after release.
- stall_cnt_o: +1 on every clock edge where pc_write_o=0 and state!=ERR and not in reset; saturates at all ones with no wrap.
- Reset asserted mid-MEM_WAIT or in ERR: immediate return to RUN with all counters cleared.

Test Plan:
- Load-use: idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5 for one cycle -> pc_write_o=0, ifid_write_o=0, idex_bubble_o=1 for 1 cycle; stall_cnt_o 0->1.
- $0 and unused rt: idex_rt_i=0, ifid_rs_i=0 -> no stall. Separately, idex_rt_i=7, ifid_rt_i=7, ifid_uses_rt_i=0 -> no stall.
- Memory wait: exmem_memaccess_i=1, dmem_ready_i low for 3 cycles then high -> pipe_freeze_o=1 for 3 cycles, 0 on the ready cycle; state RUN afterwards; stall_cnt_o=3.
- Timeout: MEM_TIMEOUT=4, dmem_ready_i held 0 -> ERR entered after 4 MEM_WAIT cycles; err_o=1 sticky; freeze held; stall_cnt_o frozen.
- Priority: branch_taken_i=1 together with loaduse -> ifid_flush_o=0, idex_bubble_o=1. Next cycle branch_taken_i=1 alone -> ifid_flush_o=1.
- Reset mid-wait: rst_i pulled low during MEM_WAIT and released -> state RUN, err_o=0, stall_cnt_o=0, pc_write_o=1 on the first cycle after release. CNT_W=2 run of 5 stall cycles -> stall_cnt_o saturates at 3.
